// File: rtl/magic_cube_pkg.sv
// rtl/magic_cube_pkg.sv - shared cube-state constants, colour codes and serializer state encodings
package magic_cube_pkg;

  localparam int FACELETS = 9;
  localparam int COLOR_W  = 3;
  localparam int SIDE_W   = FACELETS * COLOR_W;
  localparam int IDX_W    = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = 4'd8;

  localparam logic [COLOR_W-1:0] COLOR_WHITE  = 3'd0;
  localparam logic [COLOR_W-1:0] COLOR_YELLOW = 3'd1;
  localparam logic [COLOR_W-1:0] COLOR_RED    = 3'd2;
  localparam logic [COLOR_W-1:0] COLOR_ORANGE = 3'd3;
  localparam logic [COLOR_W-1:0] COLOR_BLUE   = 3'd4;
  localparam logic [COLOR_W-1:0] COLOR_GREEN  = 3'd5;
  localparam logic [COLOR_W-1:0] COLOR_SPARE  = 3'd6;
  localparam logic [COLOR_W-1:0] COLOR_EMPTY  = 3'd7;

  typedef enum logic [2:0] {
    s_idle  = 3'b000,
    s_scan  = 3'b001,
    s_emit  = 3'b011,
    s_done  = 3'b010,
    s_ready = 3'b110
  } state_t;

endpackage

// File: rtl/magic_facelet_pick.sv
// rtl/magic_facelet_pick.sv - selects one facelet colour and its one-hot position from a packed side
module magic_facelet_pick
  import magic_cube_pkg::*;
(
  input  logic [SIDE_W-1:0]   side,
  input  logic [IDX_W-1:0]    idx,
  output logic [COLOR_W-1:0]  color,
  output logic [FACELETS-1:0] position
);

  // Out-of-range indices read as an empty facelet with no position bit set.
  always_comb begin
    color    = COLOR_EMPTY;
    position = '0;
    for (int i = 0; i < FACELETS; i++) begin
      if (idx == 4'(i)) begin
        color       = side[COLOR_W*i +: COLOR_W];
        position[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/magic_side_data_get.sv
// rtl/magic_side_data_get.sv - replays a packed 27-bit side facelet by facelet on a valid/ready handshake
module magic_side_data_get
  import magic_cube_pkg::*;
#(
  parameter bit SKIP_EMPTY = 1'b1
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [SIDE_W-1:0]   oneside_din,
  input  logic                out_ready,
  output logic [FACELETS-1:0] position_coding,
  output logic [COLOR_W-1:0]  color_coding,
  output logic                out_valid,
  output logic                busy,
  output logic                done
);

  state_t              state, state_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [SIDE_W-1:0]   shadow, shadow_n;
  logic [FACELETS-1:0] pos_n;
  logic [COLOR_W-1:0]  col_n;
  logic                valid_n, busy_n, done_n;
  logic [COLOR_W-1:0]  pick_color;
  logic [FACELETS-1:0] pick_pos;

  // Always reads the latched copy so input changes mid-pass are invisible.
  magic_facelet_pick u_pick (
    .side     (shadow),
    .idx      (idx),
    .color    (pick_color),
    .position (pick_pos)
  );

  // State and every output are registered; reset aborts a pass without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= s_idle;
      idx             <= '0;
      shadow          <= '0;
      position_coding <= '0;
      color_coding    <= COLOR_EMPTY;
      out_valid       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      shadow          <= shadow_n;
      position_coding <= pos_n;
      color_coding    <= col_n;
      out_valid       <= valid_n;
      busy            <= busy_n;
      done            <= done_n;
    end
  end

  // Next-state and next-output decode; everything holds unless a state changes it.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    shadow_n = shadow;
    pos_n    = position_coding;
    col_n    = color_coding;
    valid_n  = out_valid;
    busy_n   = busy;
    done_n   = done;
    case (state)
      s_idle: begin
        if (enable) begin
          shadow_n = oneside_din;
          idx_n    = '0;
          busy_n   = 1'b1;
          state_n  = s_scan;
        end
      end
      s_scan: begin
        if (SKIP_EMPTY && (pick_color == COLOR_EMPTY)) begin
          if (idx == LAST_IDX) state_n = s_done;
          else                 idx_n   = idx + 4'd1;
        end else begin
          pos_n   = pick_pos;
          col_n   = pick_color;
          valid_n = 1'b1;
          state_n = s_emit;
        end
      end
      s_emit: begin
        if (out_valid && out_ready) begin
          valid_n = 1'b0;
          if (idx == LAST_IDX) begin
            state_n = s_done;
          end else begin
            idx_n   = idx + 4'd1;
            state_n = s_scan;
          end
        end
      end
      s_done: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        pos_n   = '0;
        col_n   = COLOR_EMPTY;
        state_n = s_ready;
      end
      s_ready: begin
        done_n  = 1'b0;
        state_n = s_idle;
      end
      default: begin
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        state_n = s_idle;
      end
    endcase
  end

endmodule

// File: tb/tb_magic_side_data_get.sv
// tb/tb_magic_side_data_get.sv - directed self-checking bench for magic_side_data_get
module tb_magic_side_data_get;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        rdy = 1'b1;
  logic        sel = 1'b0;
  logic [26:0] din = '0;

  logic       en_s, en_a;
  logic [8:0] pos_s, pos_a;
  logic [2:0] col_s, col_a;
  logic       v_s, v_a, b_s, b_a, d_s, d_a;

  logic [8:0] o_pos;
  logic [2:0] o_col;
  logic       o_valid, o_busy, o_done;

  int total = 0;
  int bad   = 0;

  logic [8:0] pos_q [0:15];
  logic [2:0] col_q [0:15];
  logic       busy_hist [0:63];
  int n_beats, done_cycle, done_cnt, busy_cnt, valid_cnt, stall_cnt, stall_bad;

  logic [8:0] exp_pos [0:8];
  logic [2:0] exp_col [0:8];

  always #5 clk = ~clk;

  assign en_s    = en & ~sel;
  assign en_a    = en & sel;
  assign o_pos   = sel ? pos_a : pos_s;
  assign o_col   = sel ? col_a : col_s;
  assign o_valid = sel ? v_a : v_s;
  assign o_busy  = sel ? b_a : b_s;
  assign o_done  = sel ? d_a : d_s;

  magic_side_data_get #(.SKIP_EMPTY(1'b1)) u_skip (
    .clk(clk), .rst(rst), .enable(en_s), .oneside_din(din), .out_ready(rdy),
    .position_coding(pos_s), .color_coding(col_s), .out_valid(v_s), .busy(b_s), .done(d_s)
  );

  magic_side_data_get #(.SKIP_EMPTY(1'b0)) u_all (
    .clk(clk), .rst(rst), .enable(en_a), .oneside_din(din), .out_ready(rdy),
    .position_coding(pos_a), .color_coding(col_a), .out_valid(v_a), .busy(b_a), .done(d_a)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts a pass on the selected DUT at the next edge (E0); sample k is taken after edge Ek.
  task automatic run_pass(input int max_cyc, input logic [8:0] stall_pos, input int stall_n,
                          input logic hold_en, input int din_k, input logic [26:0] new_din);
    int k;
    int stall_left;
    logic [8:0] sp;
    logic [2:0] sc;
    n_beats = 0; done_cycle = -1; done_cnt = 0; busy_cnt = 0;
    valid_cnt = 0; stall_cnt = 0; stall_bad = 0;
    stall_left = stall_n;
    sp = '0; sc = '0;
    en = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 64; i++) busy_hist[i] = 1'b0;
    k = 0;
    while (k < max_cyc) begin
      @(negedge clk);
      if (!hold_en) en = 1'b0;
      if (k == din_k) din = new_din;
      busy_hist[k] = o_busy;
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = k;
      end
      if (o_valid) begin
        valid_cnt++;
        if (stall_left > 0 && o_pos == stall_pos) begin
          if (stall_cnt == 0) begin sp = o_pos; sc = o_col; end
          else if (o_pos !== sp || o_col !== sc) stall_bad++;
          rdy = 1'b0;
          stall_left--;
          stall_cnt++;
        end else begin
          rdy = 1'b1;
          if (n_beats < 16) begin
            pos_q[n_beats] = o_pos;
            col_q[n_beats] = o_col;
          end
          n_beats++;
        end
      end else begin
        rdy = 1'b1;
      end
      if (done_cycle >= 0 && k >= done_cycle + 2) break;
      k++;
    end
    en = 1'b0;
    rdy = 1'b1;
  endtask

  task automatic check_beats(input string tag, input logic skip1);
    int j;
    j = 0;
    for (int i = 0; i < 9; i++) begin
      if (!(skip1 && i == 1)) begin
        if (j < n_beats && j < 16) begin
          check($sformatf("%s_pos%0d", tag, i), 32'(pos_q[j]), 32'(exp_pos[i]));
          check($sformatf("%s_col%0d", tag, i), 32'(col_q[j]), 32'(exp_col[i]));
        end
        j++;
      end
    end
  endtask

  initial begin
    int found;
    int dseen;
    int vseen;

    for (int i = 0; i < 9; i++) exp_pos[i] = 9'h001 << i;
    exp_col[0] = 3'd0; exp_col[1] = 3'd7; exp_col[2] = 3'd6; exp_col[3] = 3'd5; exp_col[4] = 3'd4;
    exp_col[5] = 3'd3; exp_col[6] = 3'd2; exp_col[7] = 3'd1; exp_col[8] = 3'd0;

    // Step 1: reset values on both instances.
    do_reset();
    check("rst_pos_s", 32'(pos_s), 32'h000);
    check("rst_col_s", 32'(col_s), 32'h7);
    check("rst_valid_s", 32'(v_s), 32'h0);
    check("rst_busy_s", 32'(b_s), 32'h0);
    check("rst_done_s", 32'(d_s), 32'h0);
    check("rst_pos_a", 32'(pos_a), 32'h000);
    check("rst_col_a", 32'(col_a), 32'h7);
    check("rst_valid_a", 32'(v_a), 32'h0);
    check("rst_busy_a", 32'(b_a), 32'h0);
    check("rst_done_a", 32'(d_a), 32'h0);

    // Step 2: skipping instance, one empty facelet dropped.
    sel = 1'b0;
    din = 27'o012345670;
    run_pass(60, 9'h000, 0, 1'b0, -1, '0);
    check("skip_beats", 32'(n_beats), 32'd8);
    check_beats("skip", 1'b1);
    check("skip_done_cnt", 32'(done_cnt), 32'd1);
    check("skip_done_cycle", 32'(done_cycle), 32'd18);
    check("skip_end_pos", 32'(o_pos), 32'h000);
    check("skip_end_col", 32'(o_col), 32'h7);

    // Step 3: non-skipping instance emits all nine, done after E19.
    sel = 1'b1;
    din = 27'o012345670;
    run_pass(60, 9'h000, 0, 1'b0, -1, '0);
    check("all_beats", 32'(n_beats), 32'd9);
    check_beats("all", 1'b0);
    check("all_done_cnt", 32'(done_cnt), 32'd1);
    check("all_done_cycle", 32'(done_cycle), 32'd19);
    check("all_busy_cnt", 32'(busy_cnt), 32'd19);

    // Step 4: five-cycle stall on facelet 3.
    sel = 1'b1;
    run_pass(80, 9'h008, 5, 1'b0, -1, '0);
    check("stall_cycles", 32'(stall_cnt), 32'd5);
    check("stall_stable", 32'(stall_bad), 32'd0);
    check("stall_beats", 32'(n_beats), 32'd9);
    check_beats("stall", 1'b0);
    check("stall_done_cycle", 32'(done_cycle), 32'd24);

    // Step 5: all-empty side on the skipping instance.
    sel = 1'b0;
    din = 27'o777777777;
    run_pass(60, 9'h000, 0, 1'b0, -1, '0);
    check("empty_valid_cnt", 32'(valid_cnt), 32'd0);
    check("empty_done_cnt", 32'(done_cnt), 32'd1);
    check("empty_busy_cnt", 32'(busy_cnt), 32'd10);
    check("empty_done_cycle", 32'(done_cycle), 32'd10);

    // Step 6: reset while facelet 4 is on the outputs, then restart.
    sel = 1'b0;
    din = 27'o012345670;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (o_valid && o_pos == 9'h010) found = 1;
      else @(negedge clk);
    end
    check("midrst_reached_f4", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_pos", 32'(o_pos), 32'h000);
    check("midrst_col", 32'(o_col), 32'h7);
    check("midrst_valid", 32'(o_valid), 32'h0);
    check("midrst_busy", 32'(o_busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    dseen = 0; vseen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_done) dseen++;
      if (o_valid) vseen++;
    end
    check("midrst_no_done", 32'(dseen), 32'd0);
    check("midrst_no_valid", 32'(vseen), 32'd0);
    run_pass(60, 9'h000, 0, 1'b0, -1, '0);
    check("restart_beats", 32'(n_beats), 32'd8);
    check("restart_first_pos", 32'(pos_q[0]), 32'h001);
    check("restart_first_col", 32'(col_q[0]), 32'h0);

    // Step 7: enable held high and input changed mid-pass.
    sel = 1'b1;
    din = 27'o012345670;
    run_pass(60, 9'h000, 0, 1'b1, 3, 27'o333333333);
    check("hold_beats", 32'(n_beats), 32'd9);
    check_beats("hold", 1'b0);
    check("hold_done_cycle", 32'(done_cycle), 32'd19);
    if (done_cycle >= 0 && done_cycle < 60) begin
      check("hold_idle_gap", 32'(busy_hist[done_cycle+1]), 32'h0);
      check("hold_restart", 32'(busy_hist[done_cycle+2]), 32'h1);
    end else begin
      check("hold_done_seen", 32'(done_cycle >= 0), 32'h1);
    end
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/magic_side_data_get.md
# magic_side_data_get

Side-colour serializer for the cube-state datapath. It takes one packed 27-bit side word (9 facelets × 3-bit colour code) and replays it facelet by facelet as a one-hot position plus colour code on a valid/ready handshake. It is the read-back counterpart of the side writer, which builds the 27-bit word from (position_coding, color_coding) pairs. It sits between the stored cube state and any downstream consumer, such as a display, UART dump or solver input.

## Interface
- SKIP_EMPTY, default 1: when 1, facelets whose colour is COLOR_EMPTY (3'b111) are not emitted.
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  start request; sampled only in s_idle.
- oneside_din  in  27  packed side; facelet i occupies bits [3i+2:3i].
- out_ready  in  1  consumer accepts the current facelet.
- position_coding  out  9  one-hot facelet index (bit i = facelet i); 0 when not emitting.
- color_coding  out  3  colour of the emitted facelet; 3'b111 when not emitting.
- out_valid  out  1  position_coding/color_coding valid.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last facelet is handled.

## Operation
- States: s_idle, s_scan, s_emit, s_done, s_ready.
- s_idle
  - If enable: latch oneside_din into the shadow register, set idx <= 0, busy <= 1, go to s_scan.
  - Otherwise stay.
- s_scan
  - Let c = shadow[3idx+2:3idx].
  - If SKIP_EMPTY and c == 3'b111:
    - idx == 8: go to s_done.
    - Otherwise: idx <= idx+1, stay.
  - Else: position_coding <= 9'b1 << idx, color_coding <= c, out_valid <= 1, go to s_emit.
- s_emit
  - Hold outputs stable until out_ready.
  - On out_valid && out_ready: out_valid <= 0.
    - idx == 8: go to s_done.
    - Otherwise: idx <= idx+1, go to s_scan.
- s_done: done <= 1, busy <= 0, position_coding <= 0, color_coding <= 3'b111, go to s_ready.
- s_ready: done <= 0, go to s_idle.
- Undefined state encodings: go to s_idle.
- idx is 4 bits and never exceeds 8. There is no wrap-around; the terminal test is idx == 8.
- The shadow register is the only source during a pass. oneside_din changes after acceptance have no effect.
- enable is ignored outside s_idle, including when it is asserted in the same cycle as done.
- All-empty side with SKIP_EMPTY=1: no out_valid at all; done is reached after 9 scan cycles.

## Timing
- Reset values:
  - State s_idle, idx 0.
  - position_coding 0, color_coding 3'b111.
  - out_valid 0, busy 0, done 0.
  - Shadow register 0.
- Reset mid-pass aborts immediately to the reset values. There is no done pulse.
- Latency, enable sampled at edge E0:
  - First out_valid is visible after E1.
  - Each emitted facelet costs 2 cycles minimum (scan + emit).
  - Each skipped facelet costs 1 cycle.
- With out_ready tied high, no skips:
  - Facelet k is valid after edge E(2k+1).
  - done is high between E19 and E20.
  - The next enable is sampled at E21.
- out_valid never drops without a handshake. Outputs are registered, with no combinational path from out_ready to any output.

## Structure
- Shared package magic_cube_pkg, holding:
  - FACELETS = 9, COLOR_W = 3, SIDE_W = 27.
  - COLOR_EMPTY = 3'b111 and the colour code constants.
  - State encodings: s_idle 3'b000, s_scan 3'b001, s_emit 3'b011, s_done 3'b010, s_ready 3'b110.
- One sub-module, magic_facelet_pick: a combinational 27-to-3 mux plus a one-hot encoder, from idx to (colour, position).

## Test plan
- SKIP_EMPTY=1, oneside_din = 27'o012345670, out_ready=1 -> 8 beats in order:
  - pos 9'h001 col 0
  - pos 9'h004 col 6
  - pos 9'h008 col 5
  - pos 9'h010 col 4
  - pos 9'h020 col 3
  - pos 9'h040 col 2
  - pos 9'h080 col 1
  - pos 9'h100 col 0
  - Then a single done pulse.
- SKIP_EMPTY=0, same input -> 9 beats including pos 9'h002 col 7; done after E19 exactly.
- out_ready held low 5 cycles on facelet 3 -> outputs stable (pos 9'h008) for the whole stall; no duplicate or lost beat.
- oneside_din = 27'o777777777 with SKIP_EMPTY=1 -> out_valid never rises; done pulses 1 cycle; busy high 10 cycles.
- rst asserted during facelet 4 -> next cycle all outputs at reset values, no done; a new enable restarts from facelet 0.
- enable held high continuously and oneside_din changed mid-pass -> emitted colours match the latched word; the next pass starts only after s_ready.
